// File: rtl/tensor_pkg.sv
// Shared tensor element and vector types for the loader and the matmul kernel.
// Element k of a vector sits at bits [k*DATA_W +: DATA_W] of its flattened word.
package tensor_pkg;

  localparam int DATA_W  = 32;
  localparam int VEC_LEN = 4;
  localparam int VEC_W   = DATA_W * VEC_LEN;

  typedef logic [DATA_W-1:0] tensor_elem_t;
  typedef tensor_elem_t [VEC_LEN-1:0] tensor_vec_t;

endpackage

// File: rtl/vec_bank.sv
// One ping-pong bank: element storage with an indexed write strobe,
// zero fill above the write index on commit, and a full flag.
module vec_bank #(
  parameter int DATA_W  = tensor_pkg::DATA_W,
  parameter int VEC_LEN = tensor_pkg::VEC_LEN,
  parameter int IDX_W   = $clog2(VEC_LEN)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_we,
  input  logic [IDX_W-1:0]          i_idx,
  input  logic [DATA_W-1:0]         i_data,
  input  logic                      i_commit,
  input  logic                      i_clr,
  output logic                      o_full,
  output logic [VEC_LEN*DATA_W-1:0] o_data
);

  logic [VEC_LEN-1:0][DATA_W-1:0] r_mem;
  logic                           r_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem  <= '0;
      r_full <= 1'b0;
    end else begin
      if (i_we) begin
        for (int k = 0; k < VEC_LEN; k++) begin
          if (k == int'(i_idx))
            r_mem[k] <= i_data;
          else if (i_commit && k > int'(i_idx))
            r_mem[k] <= '0;
        end
      end
      // commit and drain never hit the same bank in one cycle
      if (i_we && i_commit)
        r_full <= 1'b1;
      else if (i_clr)
        r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_data = r_mem;

endmodule

// File: rtl/tensor_vec_loader.sv
// Serial element stream to VEC_LEN-wide vectors through two ping-pong banks,
// with pulses for zero-padded short vectors and vectors missing s_last.
module tensor_vec_loader #(
  parameter int DATA_W  = tensor_pkg::DATA_W,
  parameter int VEC_LEN = tensor_pkg::VEC_LEN
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_W-1:0]         s_data,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [VEC_LEN*DATA_W-1:0] m_data,
  output logic                      pad_evt,
  output logic                      len_err
);

  localparam int IDX_W = $clog2(VEC_LEN);
  localparam int VEC_W = VEC_LEN * DATA_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  logic             r_wr_sel;
  logic             r_rd_sel;
  logic [IDX_W-1:0] r_wr_idx;
  logic             r_pad;
  logic             r_len_err;

  logic             w_full [2];
  logic [VEC_W-1:0] w_bank [2];
  logic             w_acc;
  logic             w_at_end;
  logic             w_commit;
  logic             w_drain;

  // s_ready depends only on registered state, never on m_ready
  assign s_ready  = !reset && !w_full[r_wr_sel];
  assign w_acc    = s_valid && s_ready;
  assign w_at_end = (r_wr_idx == LAST_IDX);
  assign w_commit = w_acc && (w_at_end || s_last);

  assign m_valid  = w_full[r_rd_sel];
  assign m_data   = w_bank[r_rd_sel];
  assign w_drain  = m_valid && m_ready;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    vec_bank #(
      .DATA_W (DATA_W),
      .VEC_LEN(VEC_LEN),
      .IDX_W  (IDX_W)
    ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .i_we    (w_acc && (r_wr_sel == 1'(g))),
      .i_idx   (r_wr_idx),
      .i_data  (s_data),
      .i_commit(w_commit),
      .i_clr   (w_drain && (r_rd_sel == 1'(g))),
      .o_full  (w_full[g]),
      .o_data  (w_bank[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_sel  <= 1'b0;
      r_rd_sel  <= 1'b0;
      r_wr_idx  <= '0;
      r_pad     <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      r_pad     <= w_commit && !w_at_end;
      r_len_err <= w_acc && w_at_end && !s_last;
      if (w_acc) begin
        if (w_commit) begin
          r_wr_idx <= '0;
          r_wr_sel <= !r_wr_sel;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end
      if (w_drain)
        r_rd_sel <= !r_rd_sel;
    end
  end

  assign pad_evt = r_pad;
  assign len_err = r_len_err;

endmodule

// File: tb/tb_tensor_vec_loader.sv
// Directed table plus multi-cycle sequences for tensor_vec_loader.
module tb_tensor_vec_loader;
  import tensor_pkg::*;

  localparam int VL = VEC_LEN;

  logic               clk = 1'b0;
  logic               reset;
  logic               s_valid;
  logic               s_ready;
  logic [DATA_W-1:0]  s_data;
  logic               s_last;
  logic               m_valid;
  logic               m_ready;
  logic [VEC_W-1:0]   m_data;
  logic               pad_evt;
  logic               len_err;

  int n_checks = 0;
  int n_err    = 0;

  tensor_vec_loader dut (
    .clk    (clk),
    .reset  (reset),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_last (s_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .pad_evt(pad_evt),
    .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        l;
    logic        e_mv;
    tensor_vec_t e_md;
    logic        e_pad;
    logic        e_len;
  } row_t;

  row_t tbl [15];

  function automatic tensor_vec_t vec4(input int a, input int b,
                                       input int c, input int d);
    tensor_vec_t v;
    v[0] = 32'(a);
    v[1] = 32'(b);
    v[2] = 32'(c);
    v[3] = 32'(d);
    return v;
  endfunction

  function automatic row_t mk(input logic v, input int d, input logic l,
                              input logic mv, input tensor_vec_t md,
                              input logic pd, input logic le);
    row_t r;
    r.v = v; r.d = 32'(d); r.l = l;
    r.e_mv = mv; r.e_md = md; r.e_pad = pd; r.e_len = le;
    return r;
  endfunction

  function automatic tensor_vec_t exp_vec(input int first, input int step,
                                          input int idx);
    tensor_vec_t v;
    for (int k = 0; k < VL; k++)
      v[k] = 32'(first + step * (idx * VL + k));
    return v;
  endfunction

  task automatic check(input string nm, input logic [VEC_W-1:0] act,
                       input logic [VEC_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run(input int n, input int first, input int step,
                     input int ready_after, input bit chk_hold,
                     input string nm, output int stalls);
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    int evts = 0;
    stalls = 0;
    while (got < n / VL && cyc < 400) begin
      @(posedge clk); #1;
      m_ready = (cyc >= ready_after);
      s_valid = (sent < n);
      s_data  = 32'(first + step * sent);
      s_last  = (sent % VL == VL - 1);
      @(negedge clk);
      if (chk_hold && cyc == ready_after - 1) begin
        check({nm, "_sent"}, 32'(sent), 32'd8);
        check({nm, "_full_rdy"}, s_ready, 1'b0);
        check({nm, "_hold_mv"}, m_valid, 1'b1);
        check({nm, "_hold_md"}, m_data, vec4(1, 2, 3, 4));
      end
      if (s_valid && !s_ready) stalls++;
      if (pad_evt || len_err) evts++;
      if (s_valid && s_ready) sent++;
      if (m_valid && m_ready) begin
        check(nm, m_data, exp_vec(first, step, got));
        got++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    check({nm, "_count"}, 32'(got), 32'(n / VL));
    check({nm, "_evts"}, 32'(evts), 32'd0);
  endtask

  initial begin
    int st;

    tbl[0]  = mk(1, 1, 0, 0, '0, 0, 0);
    tbl[1]  = mk(1, 2, 0, 0, '0, 0, 0);
    tbl[2]  = mk(1, 3, 0, 0, '0, 0, 0);
    tbl[3]  = mk(1, 4, 1, 0, '0, 0, 0);
    tbl[4]  = mk(1, 7, 0, 1, vec4(1, 2, 3, 4), 0, 0);
    tbl[5]  = mk(1, 8, 1, 0, '0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 1, vec4(7, 8, 0, 0), 1, 0);
    tbl[7]  = mk(0, 0, 0, 0, '0, 0, 0);
    tbl[8]  = mk(1, 1, 0, 0, '0, 0, 0);
    tbl[9]  = mk(1, 2, 0, 0, '0, 0, 0);
    tbl[10] = mk(1, 3, 0, 0, '0, 0, 0);
    tbl[11] = mk(1, 4, 0, 0, '0, 0, 0);
    tbl[12] = mk(1, 5, 1, 1, vec4(1, 2, 3, 4), 0, 1);
    tbl[13] = mk(0, 0, 0, 1, vec4(5, 0, 0, 0), 1, 0);
    tbl[14] = mk(0, 0, 0, 0, '0, 0, 0);

    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;

    @(negedge clk);
    check("rst_srdy", s_ready, 1'b0);
    check("rst_mv", m_valid, 1'b0);
    check("rst_md", m_data, '0);
    check("rst_pad", pad_evt, 1'b0);
    check("rst_len", len_err, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      s_valid = tbl[i].v;
      s_data  = tbl[i].d;
      s_last  = tbl[i].l;
      m_ready = 1'b1;
      @(negedge clk);
      check($sformatf("row%0d_srdy", i), s_ready, 1'b1);
      check($sformatf("row%0d_mv", i), m_valid, tbl[i].e_mv);
      check($sformatf("row%0d_pad", i), pad_evt, tbl[i].e_pad);
      check($sformatf("row%0d_len", i), len_err, tbl[i].e_len);
      if (tbl[i].e_mv)
        check($sformatf("row%0d_md", i), m_data, tbl[i].e_md);
    end

    run(12, 1, 1, 12, 1'b1, "t3_vec", st);

    m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = 32'd99;
    s_last  = 1'b0;
    @(negedge clk);
    check("t5_acc0", s_ready, 1'b1);
    @(posedge clk); #1;
    s_data = 32'd98;
    @(negedge clk);
    check("t5_acc1", s_ready, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    check("t5_rst_srdy", s_ready, 1'b0);
    check("t5_rst_mv", m_valid, 1'b0);
    check("t5_rst_md", m_data, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t5_rel_srdy", s_ready, 1'b1);
    check("t5_rel_mv", m_valid, 1'b0);
    run(4, 10, 10, 0, 1'b0, "t5_vec", st);

    run(64, 1000, 1, 0, 1'b0, "t6_vec", st);
    check("t6_stalls", 32'(st), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
